// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back data cache controller:
// default address-field widths, bus widths, FSM state encodings and
// address-field helpers for the default geometry.
package dcache_ctrl_pkg;

    localparam int unsigned DC_ADDR_WIDTH   = 32;
    localparam int unsigned DC_WORD_WIDTH   = 32;
    localparam int unsigned DC_BE_WIDTH     = DC_WORD_WIDTH / 8;
    localparam int unsigned DC_TAG_WIDTH    = 20;
    localparam int unsigned DC_INDEX_WIDTH  = 6;
    localparam int unsigned DC_OFFSET_WIDTH = 4;

    // Controller states; encodings are fixed so traces stay readable.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WB     = 2'd1,
        ST_REFILL = 2'd2
    } dc_state_e;

    // Address-field extraction for the default geometry.
    function automatic logic [DC_TAG_WIDTH-1:0] dc_addr_tag(input logic [DC_ADDR_WIDTH-1:0] addr);
        return addr[DC_ADDR_WIDTH-1 -: DC_TAG_WIDTH];
    endfunction

    function automatic logic [DC_INDEX_WIDTH-1:0] dc_addr_index(input logic [DC_ADDR_WIDTH-1:0] addr);
        return addr[DC_OFFSET_WIDTH+2 +: DC_INDEX_WIDTH];
    endfunction

    function automatic logic [DC_OFFSET_WIDTH-1:0] dc_addr_offset(input logic [DC_ADDR_WIDTH-1:0] addr);
        return addr[2 +: DC_OFFSET_WIDTH];
    endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Sits between one CPU load/store port, the per-line cache storage
// (valid/dirty/tag + word-addressed data, instantiated by the parent) and a
// word-wide memory port with a request/ready handshake.
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   cpu_en/wen/addr/wdata    CPU request, held stable until cpu_ready
//   cpu_rdata, cpu_ready     load data and completion (same cycle on a hit)
//   line_index/offset        storage selection
//   line_*_in, line_write_en storage write port
//   line_*_out               storage read port for the selected line/word
//   mem_en/wen/addr/wdata    memory word request (write-back or refill)
//   mem_rdata, mem_ready     memory response / acceptance
//
// Hit/miss is decided combinationally from the selected line. A miss on a
// dirty line writes back all words of the victim, then refills the line one
// word per accepted memory read; the request then completes as a hit.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int unsigned TAG_WIDTH    = DC_TAG_WIDTH,
    parameter int unsigned INDEX_WIDTH  = DC_INDEX_WIDTH,
    parameter int unsigned OFFSET_WIDTH = DC_OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cpu_en,
    input  logic [3:0]              cpu_wen,
    input  logic [31:0]             cpu_addr,
    input  logic [31:0]             cpu_wdata,
    output logic [31:0]             cpu_rdata,
    output logic                    cpu_ready,

    output logic [INDEX_WIDTH-1:0]  line_index,
    output logic [OFFSET_WIDTH-1:0] line_offset,
    output logic                    line_write_en,
    output logic                    line_valid_in,
    output logic                    line_dirty_in,
    output logic [TAG_WIDTH-1:0]    line_tag_in,
    output logic [3:0]              line_byte_en,
    output logic [31:0]             line_data_in,
    input  logic                    line_valid_out,
    input  logic                    line_dirty_out,
    input  logic [TAG_WIDTH-1:0]    line_tag_out,
    input  logic [31:0]             line_data_out,

    output logic                    mem_en,
    output logic                    mem_wen,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata,
    input  logic                    mem_ready
);

    // Address fields must tile a 32-bit byte address exactly.
    if (TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH + 2 != 32) begin : g_bad_split
        $error("dcache_ctrl: TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH+2 must equal 32");
    end

    dc_state_e               state_q, state_d;
    logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;

    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_index;
    logic [OFFSET_WIDTH-1:0] req_offset;
    logic                    hit;
    logic                    cnt_last;
    logic                    unused_addr_bits;

    // Request address split; byte selection comes from cpu_wen only.
    assign req_tag          = cpu_addr[31 -: TAG_WIDTH];
    assign req_index        = cpu_addr[OFFSET_WIDTH+2 +: INDEX_WIDTH];
    assign req_offset       = cpu_addr[2 +: OFFSET_WIDTH];
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign hit      = line_valid_out && (line_tag_out == req_tag);
    assign cnt_last = (cnt_q == {OFFSET_WIDTH{1'b1}});

    // State and word counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and all port outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;

        cpu_rdata     = '0;
        cpu_ready     = 1'b0;

        line_index    = req_index;
        line_offset   = req_offset;
        line_write_en = 1'b0;
        line_valid_in = 1'b0;
        line_dirty_in = 1'b0;
        line_tag_in   = '0;
        line_byte_en  = '0;
        line_data_in  = '0;

        mem_en        = 1'b0;
        mem_wen       = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_en) begin
                    if (hit) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = line_data_out;
                        // Store hit merges bytes in place and marks the line dirty.
                        if (cpu_wen != 4'b0000) begin
                            line_write_en = 1'b1;
                            line_valid_in = 1'b1;
                            line_dirty_in = 1'b1;
                            line_tag_in   = req_tag;
                            line_byte_en  = cpu_wen;
                            line_data_in  = cpu_wdata;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = line_dirty_out ? ST_WB : ST_REFILL;
                    end
                end
            end

            ST_WB: begin
                // Victim address is rebuilt from the stored tag, not the request.
                line_offset = cnt_q;
                mem_en      = 1'b1;
                mem_wen     = 1'b1;
                mem_addr    = {line_tag_out, req_index, cnt_q, 2'b00};
                mem_wdata   = line_data_out;
                if (mem_ready) begin
                    cnt_d = cnt_q + OFFSET_WIDTH'(1);
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = ST_REFILL;
                    end
                end
            end

            ST_REFILL: begin
                line_offset = cnt_q;
                mem_en      = 1'b1;
                mem_addr    = {req_tag, req_index, cnt_q, 2'b00};
                if (mem_ready) begin
                    line_write_en = 1'b1;
                    line_valid_in = 1'b1;
                    line_tag_in   = req_tag;
                    line_byte_en  = 4'hf;
                    line_data_in  = mem_rdata;
                    cnt_d         = cnt_q + OFFSET_WIDTH'(1);
                    // Back to IDLE; the held request then completes as a hit.
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: models the line storage and a zero-wait
// memory that returns data equal to the word address.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic [5:0]  line_index;
    logic [3:0]  line_offset;
    logic        line_write_en;
    logic        line_valid_in;
    logic        line_dirty_in;
    logic [19:0] line_tag_in;
    logic [3:0]  line_byte_en;
    logic [31:0] line_data_in;
    logic        line_valid_out;
    logic        line_dirty_out;
    logic [19:0] line_tag_out;
    logic [31:0] line_data_out;
    logic        mem_en;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        stall = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] rd_addr_q[$];

    // Line storage model.
    logic        st_valid [64];
    logic        st_dirty [64];
    logic [19:0] st_tag   [64];
    logic [31:0] st_data  [64][16];

    dcache_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_en         (cpu_en),
        .cpu_wen        (cpu_wen),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_ready      (cpu_ready),
        .line_index     (line_index),
        .line_offset    (line_offset),
        .line_write_en  (line_write_en),
        .line_valid_in  (line_valid_in),
        .line_dirty_in  (line_dirty_in),
        .line_tag_in    (line_tag_in),
        .line_byte_en   (line_byte_en),
        .line_data_in   (line_data_in),
        .line_valid_out (line_valid_out),
        .line_dirty_out (line_dirty_out),
        .line_tag_out   (line_tag_out),
        .line_data_out  (line_data_out),
        .mem_en         (mem_en),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign line_valid_out = st_valid[line_index];
    assign line_dirty_out = st_valid[line_index] && st_dirty[line_index];
    assign line_tag_out   = st_tag[line_index];
    assign line_data_out  = st_valid[line_index] ? st_data[line_index][line_offset] : 32'h0;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) st_valid[i] <= 1'b0;
        end else if (line_write_en) begin
            st_valid[line_index] <= line_valid_in;
            st_dirty[line_index] <= line_dirty_in;
            st_tag[line_index]   <= line_tag_in;
            for (int b = 0; b < 4; b++)
                if (line_byte_en[b])
                    st_data[line_index][line_offset][8*b +: 8] <= line_data_in[8*b +: 8];
        end
    end

    // Memory: read data equals address; handshakes are logged.
    assign mem_ready = mem_en && !stall;
    assign mem_rdata = mem_addr;

    always @(posedge clk) begin
        if (mem_en && mem_ready) begin
            if (mem_wen) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end else begin
                rd_addr_q.push_back(mem_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge; returns cycles to cpu_ready and rdata.
    task automatic do_req(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata);
        int start;
        cpu_addr  = addr;
        cpu_wen   = wen;
        cpu_wdata = wdata;
        cpu_en    = 1'b1;
        start     = cyc;
        #1;
        for (int i = 0; i < 200 && !cpu_ready; i++) begin
            @(negedge clk);
            #1;
        end
        check("req_ready", 32'(cpu_ready), 32'd1);
        lat   = cyc - start;
        rdata = cpu_rdata;
        @(negedge clk);
        cpu_en  = 1'b0;
        cpu_wen = 4'b0000;
    endtask

    initial begin
        int          lat;
        int          start;
        int          s_wr;
        int          s_rd;
        logic [31:0] rdata;

        for (int i = 0; i < 64; i++) begin
            st_dirty[i] = 1'b0;
            st_tag[i]   = '0;
            for (int w = 0; w < 16; w++) st_data[i][w] = '0;
        end
        rst       = 1'b0;
        cpu_en    = 1'b0;
        cpu_wen   = 4'b0000;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_line_we", 32'(line_write_en), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Clean miss: 16 reads, ready 17 cycles after cpu_en.
        s_rd = rd_addr_q.size();
        do_req(32'h0000_1040, 4'b0000, 32'h0, lat, rdata);
        check("miss_latency", 32'(lat), 32'd17);
        check("miss_rdata", rdata, 32'h0000_1040);
        check("miss_nreads", 32'(rd_addr_q.size() - s_rd), 32'd16);
        check("miss_rd_first", rd_addr_q[s_rd], 32'h0000_1040);
        check("miss_rd_last", rd_addr_q[s_rd+15], 32'h0000_107C);

        // Load hit.
        s_rd = rd_addr_q.size();
        do_req(32'h0000_1044, 4'b0000, 32'h0, lat, rdata);
        check("hit_latency", 32'(lat), 32'd0);
        check("hit_rdata", rdata, 32'h0000_1044);
        check("hit_no_mem", 32'(rd_addr_q.size() - s_rd), 32'd0);
        check("hit_mem_en", 32'(mem_en), 32'd0);

        // Store hit with partial byte enables, then read back.
        cpu_addr  = 32'h0000_1044;
        cpu_wen   = 4'b0011;
        cpu_wdata = 32'hDEAD_BEEF;
        cpu_en    = 1'b1;
        #1;
        check("st_ready", 32'(cpu_ready), 32'd1);
        check("st_line_we", 32'(line_write_en), 32'd1);
        check("st_byte_en", 32'(line_byte_en), 32'h3);
        check("st_dirty_in", 32'(line_dirty_in), 32'd1);
        @(negedge clk);
        cpu_en  = 1'b0;
        cpu_wen = 4'b0000;
        do_req(32'h0000_1044, 4'b0000, 32'h0, lat, rdata);
        check("st_readback", rdata, 32'h0000_BEEF);

        // Dirty conflict miss with a 5-cycle stall at refill word 7.
        s_wr      = wr_addr_q.size();
        s_rd      = rd_addr_q.size();
        cpu_addr  = 32'h0000_2040;
        cpu_wen   = 4'b0000;
        cpu_en    = 1'b1;
        start     = cyc;
        #1;
        for (int i = 0; i < 100 && !(mem_en && !mem_wen && mem_addr == 32'h0000_205C); i++) begin
            @(negedge clk);
            #1;
        end
        check("stall_reach", mem_addr, 32'h0000_205C);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("stall_hold_addr", mem_addr, 32'h0000_205C);
        end
        check("stall_offset", 32'(line_offset), 32'd7);
        stall = 1'b0;
        for (int i = 0; i < 100 && !cpu_ready; i++) begin
            @(negedge clk);
            #1;
        end
        check("wb_ready", 32'(cpu_ready), 32'd1);
        check("wb_latency", 32'(cyc - start), 32'd38);
        check("wb_rdata", cpu_rdata, 32'h0000_2040);
        @(negedge clk);
        cpu_en = 1'b0;
        check("wb_nwrites", 32'(wr_addr_q.size() - s_wr), 32'd16);
        check("wb_wr_first", wr_addr_q[s_wr], 32'h0000_1040);
        check("wb_wr_last", wr_addr_q[s_wr+15], 32'h0000_107C);
        check("wb_wdata0", wr_data_q[s_wr], 32'h0000_1040);
        check("wb_wdata1", wr_data_q[s_wr+1], 32'h0000_BEEF);
        check("rf_nreads", 32'(rd_addr_q.size() - s_rd), 32'd16);
        check("rf_rd_first", rd_addr_q[s_rd], 32'h0000_2040);
        check("rf_rd7", rd_addr_q[s_rd+7], 32'h0000_205C);
        check("rf_rd8", rd_addr_q[s_rd+8], 32'h0000_2060);

        // Dirty the line, then reset in the middle of its write-back.
        do_req(32'h0000_2040, 4'b1111, 32'h1234_5678, lat, rdata);
        check("st2_latency", 32'(lat), 32'd0);
        s_wr     = wr_addr_q.size();
        cpu_addr = 32'h0000_3040;
        cpu_en   = 1'b1;
        #1;
        for (int i = 0; i < 100 && !(mem_en && mem_wen && mem_addr == 32'h0000_204C); i++) begin
            @(negedge clk);
            #1;
        end
        check("rstwb_reach", mem_addr, 32'h0000_204C);
        rst   = 1'b0;
        stall = 1'b1;
        @(negedge clk);
        rst    = 1'b1;
        stall  = 1'b0;
        cpu_en = 1'b0;
        #1;
        check("rstwb_mem_en", 32'(mem_en), 32'd0);
        check("rstwb_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rstwb_line_we", 32'(line_write_en), 32'd0);
        check("rstwb_nwrites", 32'(wr_addr_q.size() - s_wr), 32'd3);
        @(negedge clk);
        s_rd = rd_addr_q.size();
        do_req(32'h0000_3040, 4'b0000, 32'h0, lat, rdata);
        check("reissue_latency", 32'(lat), 32'd17);
        check("reissue_rdata", rdata, 32'h0000_3040);
        check("reissue_rd_first", rd_addr_q[s_rd], 32'h0000_3040);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Controller for a direct-mapped, write-back, write-allocate data cache built from the team's per-line cache storage (valid/dirty/tag plus word-addressed data array).
- Serves one CPU load/store port.
- Decides hit or miss combinationally from the selected line's outputs.
- On a miss, writes back a dirty victim word-by-word, then refills the line from memory over a per-word request/ready handshake.

Parameters:
TAG_WIDTH, 20, tag bits; address bits [31:32-TAG_WIDTH]
INDEX_WIDTH, 6, line index bits; 2**INDEX_WIDTH lines
OFFSET_WIDTH, 4, word-offset bits; 2**OFFSET_WIDTH 32-bit words per line
Constraint: TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH+2 == 32. Elaboration fails otherwise.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
cpu_en  in  1  CPU request valid; cpu_addr/cpu_wen/cpu_wdata are held stable until cpu_ready
cpu_wen  in  4  byte write enables; 0 = load
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data, valid when cpu_ready
cpu_ready  out  1  request completes this cycle
line_index  out  INDEX_WIDTH  selected line
line_offset  out  OFFSET_WIDTH  selected word
line_write_en  out  1  line write strobe
line_valid_in  out  1  valid to write
line_dirty_in  out  1  dirty to write
line_tag_in  out  TAG_WIDTH  tag to write
line_byte_en  out  4  data byte enables
line_data_in  out  32  data to write
line_valid_out  in  1  selected line valid
line_dirty_out  in  1  selected line dirty (0 when invalid)
line_tag_out  in  TAG_WIDTH  selected line tag
line_data_out  in  32  word at line_offset (0 when invalid)
mem_en  out  1  memory word request valid
mem_wen  out  1  1 = write word, 0 = read word
mem_addr  out  32  word-aligned address
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid with mem_ready on a read
mem_ready  in  1  current word accepted/returned this cycle

Behaviour:
- Address split:
  - tag = cpu_addr[31 -: TAG_WIDTH]
  - index = next INDEX_WIDTH bits
  - offset = cpu_addr[OFFSET_WIDTH+1:2]
  - cpu_addr[1:0] ignored; byte selection is via cpu_wen.
- line_index is always the index of cpu_addr.
- line_offset = offset in IDLE; = cnt in WB and REFILL.
- hit = line_valid_out && line_tag_out == tag.
- FSM states: IDLE, WB, REFILL.
- IDLE:
  - cpu_en && hit: cpu_ready=1 in the same cycle, cpu_rdata = line_data_out.
  - If cpu_wen != 0 on a hit: line_write_en=1, line_byte_en=cpu_wen, line_data_in=cpu_wdata, valid_in=1, dirty_in=1, tag_in=tag.
  - cpu_en && !hit && line_dirty_out: go to WB, cnt=0.
  - cpu_en && !hit && !line_dirty_out: go to REFILL, cnt=0.
- WB:
  - mem_en=1, mem_wen=1.
  - mem_addr = {line_tag_out, index, cnt, 2'b00}; mem_wdata = line_data_out.
  - On mem_ready: cnt++.
  - On mem_ready with cnt == all-ones: go to REFILL, cnt=0.
- REFILL:
  - mem_en=1, mem_wen=0, mem_addr = {tag, index, cnt, 2'b00}.
  - On mem_ready: line_write_en=1, byte_en=4'hf, data_in=mem_rdata, valid_in=1, dirty_in=0, tag_in=tag; cnt++.
  - On the last word: return to IDLE. The request is re-evaluated there and completes as a hit one cycle later.
- Miss latency (clean victim, zero-wait memory): 2**OFFSET_WIDTH + 1 cycles to cpu_ready.
- Dirty victim adds 2**OFFSET_WIDTH cycles.
- cpu_ready=0 outside IDLE. line_write_en=0 except in the cases above. mem_en=0 in IDLE.
- Stalled mem_ready (held 0): all outputs hold; cnt does not advance.
- cpu_en=0 in IDLE: no line write, no memory traffic.
- Reset (rst==0 at a clock edge, any state including mid-WB/REFILL):
  - state=IDLE, cnt=0.
  - All registered outputs 0; combinational outputs follow the IDLE equations.
  - Partially refilled lines keep stale words. Line valid bits are cleared by the storage's own reset.

Decomposition:
- Shared cache header holds the state encodings (IDLE=2'd0, WB=2'd1, REFILL=2'd2) and address-field macros for tag/index/offset extraction.
- No sub-module. The word counter and FSM live in one module; the line storage array is instantiated by the parent, not here.

Test Plan:
- After reset, load 0x0000_1040 (index 1, offset 0) → REFILL issues reads 0x1040..0x107C. Memory returns value = addr. cpu_ready asserts 17 cycles after cpu_en, cpu_rdata=0x0000_1040.
- Repeat load 0x0000_1044 → cpu_ready in the same cycle, rdata=0x0000_1044, mem_en stays 0.
- Store 0xDEADBEEF with cpu_wen=4'b0011 to 0x1044 → one-cycle ready; a subsequent load returns 0x0000BEEF.
- Load 0x0000_2040 (same index, new tag) → 16 writes at 0x1040..0x107C with word 1 = 0x0000BEEF, then 16 reads from 0x2040.
- mem_ready held low for 5 cycles mid-refill at cnt=7 → mem_addr stays 0x205C; cnt resumes at 8 when ready returns.
- rst low during WB at cnt=3 → next cycle state IDLE, mem_en=0, cpu_ready=0; the request reissued after reset completes correctly.
